ahb_to_ssram: RTL

AHB-Lite responder (slave) that maps HADDR onto a single-port synchronous SRAM with one-cycle read latency, at zero wait states. It is the responder counterpart of the team's AHB-Lite bench driver and sits behind the interconnect's slave select.
A one-entry write buffer defers data-phase writes that collide with a read address phase. Reads merge buffered bytes, so the SRAM port never needs a stall.

---
 rtl/ahb_to_ssram_if.sv | 26 ++
 rtl/ahb_to_ssram.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ahb_to_ssram_if.sv
// AHB-Lite responder-side bus bundle for ahb_to_ssram.
// The master modport drives the request side; the slave modport drives the response side.
interface ahb_to_ssram_if #(
  parameter int unsigned AW = 12
) ();
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_to_ssram.sv
// Zero-wait-state AHB-Lite responder in front of a single-port synchronous SRAM.
// Writes that collide with a read address phase park in a one-entry buffer merged into reads.
module ahb_to_ssram #(
  parameter int unsigned AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_to_ssram_if.slave ahb,
  output logic [AW-3:0] SSRAM_ADDR,
  output logic          SSRAM_CS,
  output logic [3:0]    SSRAM_WEN,
  output logic [31:0]   SSRAM_WDATA,
  input  logic [31:0]   SSRAM_RDATA
);

  localparam int unsigned WW = AW - 2;

  logic          valid, rd_ap, wr_ap;
  logic [3:0]    ap_mask;
  logic [WW-1:0] ap_addr;

  logic          wr_dp, rd_dp;
  logic [WW-1:0] wr_addr;
  logic [3:0]    wr_mask;
  logic          buf_valid;
  logic [WW-1:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;
  logic [3:0]    rd_hit_mask;
  logic [3:0]    hit_mask;
  logic [31:0]   hrdata_q;
  logic [31:0]   merged;

  logic          cs;
  logic [3:0]    wen;
  logic [WW-1:0] addr;
  logic [31:0]   wdata;
  logic          buf_drain;

  assign valid   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign rd_ap   = valid & ~ahb.HWRITE;
  assign wr_ap   = valid & ahb.HWRITE;
  assign ap_addr = ahb.HADDR[AW-1:2];

  always_comb begin
    case (ahb.HSIZE)
      3'd0:    ap_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    ap_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
  end

  // Reads own the SRAM port; writes fall back to direct data phase, then the buffer.
  always_comb begin
    cs        = 1'b0;
    wen       = 4'b0000;
    addr      = ap_addr;
    wdata     = ahb.HWDATA;
    buf_drain = 1'b0;
    if (rd_ap) begin
      cs = 1'b1;
    end else if (wr_dp) begin
      cs   = 1'b1;
      wen  = wr_mask;
      addr = wr_addr;
    end else if (buf_valid) begin
      cs        = 1'b1;
      wen       = buf_mask;
      addr      = buf_addr;
      wdata     = buf_data;
      buf_drain = 1'b1;
    end
  end

  assign SSRAM_CS    = cs & HRESETn;
  assign SSRAM_WEN   = HRESETn ? wen : 4'b0000;
  assign SSRAM_ADDR  = addr;
  assign SSRAM_WDATA = wdata;

  // A colliding write is loaded into the buffer this edge, so a hit on it reads buf_data next cycle.
  always_comb begin
    if (wr_dp && (wr_addr == ap_addr)) begin
      hit_mask = wr_mask;
    end else if (buf_valid && (buf_addr == ap_addr)) begin
      hit_mask = buf_mask;
    end else begin
      hit_mask = 4'b0000;
    end
  end

  always_comb begin
    merged = SSRAM_RDATA;
    for (int i = 0; i < 4; i++) begin
      if (rd_hit_mask[i]) merged[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_dp       <= 1'b0;
      rd_dp       <= 1'b0;
      wr_addr     <= '0;
      wr_mask     <= 4'b0000;
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_mask    <= 4'b0000;
      buf_data    <= 32'h0;
      rd_hit_mask <= 4'b0000;
      hrdata_q    <= 32'h0;
    end else begin
      wr_dp <= wr_ap;
      rd_dp <= rd_ap;
      if (wr_ap) begin
        wr_addr <= ap_addr;
        wr_mask <= ap_mask;
      end
      if (rd_ap && wr_dp) begin
        buf_valid <= 1'b1;
        buf_addr  <= wr_addr;
        buf_mask  <= wr_mask;
        buf_data  <= ahb.HWDATA;
      end else if (buf_drain) begin
        buf_valid <= 1'b0;
      end
      if (rd_ap) rd_hit_mask <= hit_mask;
      if (rd_dp) hrdata_q <= merged;
    end
  end

  assign ahb.HRDATA    = rd_dp ? merged : hrdata_q;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

endmodule
